// File: rtl/ps2_key_decoder.sv
// Key-event decoder for a ps2_keyboard byte stream. Merges E0/F0 prefixes into
// make/break events, flags typematic repeats, tracks modifiers, counts presses in BCD.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [7:0]              in_data,
  input  logic                    in_ready,
  output logic                    in_nextdata_n,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [7:0]              evt_code,
  output logic                    evt_ext,
  output logic                    evt_break,
  output logic                    evt_repeat,
  output logic                    overflow,
  output logic [4*CNT_DIGITS-1:0] press_count,
  output logic                    held_valid,
  output logic                    held_ext,
  output logic [7:0]              held_code,
  output logic                    shift,
  output logic                    ctrl
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 11;
  localparam logic [ADDR_W:0] DEPTH_PTR = (ADDR_W + 1)'(FIFO_DEPTH);

  // Modifier slots: left shift, right shift, left ctrl, right ctrl (E0 14)
  localparam logic [31:0] MOD_CODES = {8'h14, 8'h14, 8'h59, 8'h12};
  localparam logic [3:0]  MOD_EXTS  = 4'b1000;

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

  // ---------------------------------------------------------------
  // Byte acceptance: one-cycle low acknowledge, then one cycle re-arm
  // ---------------------------------------------------------------
  logic ack_n_reg;
  logic capture;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      ack_n_reg <= 1'b1;
    end else if (!ack_n_reg) begin
      ack_n_reg <= 1'b1;
    end else if (in_ready) begin
      ack_n_reg <= 1'b0;
    end
  end

  assign capture       = in_ready & ack_n_reg;
  assign in_nextdata_n = ack_n_reg;

  // ---------------------------------------------------------------
  // Prefix FSM
  // ---------------------------------------------------------------
  state_t state_reg, state_next;
  logic   is_e0, is_f0, is_discard;
  logic   emit, emit_ext, emit_break;

  assign is_e0      = (in_data == 8'hE0);
  assign is_f0      = (in_data == 8'hF0);
  assign is_discard = (in_data == 8'h00) | (in_data == 8'hFF) | (in_data == 8'hE1);

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A prefix arriving in an unexpected state restarts decoding from IDLE
  always_comb begin
    state_next = state_reg;
    if (capture) begin
      if (is_e0) begin
        state_next = ST_E0;
      end else if (is_f0) begin
        state_next = (state_reg == ST_E0) ? ST_E0F0 : ST_F0;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_comb begin
    emit       = capture & ~is_e0 & ~is_f0 & ~is_discard;
    emit_ext   = (state_reg == ST_E0) | (state_reg == ST_E0F0);
    emit_break = (state_reg == ST_F0) | (state_reg == ST_E0F0);
  end

  // ---------------------------------------------------------------
  // Held key and repeat detection
  // ---------------------------------------------------------------
  logic       held_valid_reg, held_ext_reg;
  logic [7:0] held_code_reg;
  logic       held_match, emit_repeat, new_press;

  assign held_match  = held_valid_reg & (held_ext_reg == emit_ext) & (held_code_reg == in_data);
  assign emit_repeat = ~emit_break & held_match;
  assign new_press   = emit & ~emit_break & ~held_match;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      held_valid_reg <= 1'b0;
      held_ext_reg   <= 1'b0;
      held_code_reg  <= 8'h00;
    end else if (new_press) begin
      held_valid_reg <= 1'b1;
      held_ext_reg   <= emit_ext;
      held_code_reg  <= in_data;
    end else if (emit & emit_break & held_match) begin
      held_valid_reg <= 1'b0;
    end
  end

  assign held_valid = held_valid_reg;
  assign held_ext   = held_ext_reg;
  assign held_code  = held_code_reg;

  // ---------------------------------------------------------------
  // Modifiers: each physical key tracked separately
  // ---------------------------------------------------------------
  logic [3:0] mod_reg;
  logic [3:0] mod_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mod
    assign mod_hit[gi] = emit & (in_data == MOD_CODES[gi*8 +: 8]) & (emit_ext == MOD_EXTS[gi]);
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      mod_reg <= 4'b0000;
    end else begin
      mod_reg <= (mod_reg & ~mod_hit) | (mod_hit & {4{~emit_break}});
    end
  end

  assign shift = mod_reg[0] | mod_reg[1];
  assign ctrl  = mod_reg[2] | mod_reg[3];

  // ---------------------------------------------------------------
  // BCD press counter, ripple carry between digits
  // ---------------------------------------------------------------
  logic [4*CNT_DIGITS-1:0] count_reg, count_next;
  logic [CNT_DIGITS-1:0]   carry;

  assign carry[0] = new_press;

  for (genvar gi = 0; gi < CNT_DIGITS; gi++) begin : g_bcd
    logic [3:0] digit;
    assign digit = count_reg[4*gi +: 4];
    assign count_next[4*gi +: 4] = !carry[gi]      ? digit :
                                   (digit == 4'd9) ? 4'd0  : digit + 4'd1;
    if (gi < CNT_DIGITS - 1) begin : g_carry
      assign carry[gi+1] = carry[gi] & (digit == 4'd9);
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign press_count = count_reg;

  // ---------------------------------------------------------------
  // Event FIFO, first-word-fall-through, no write bypass
  // ---------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]    wr_ptr_reg, rd_ptr_reg;
  logic               fifo_empty, fifo_full, push, pop;
  logic [ENTRY_W-1:0] head;
  logic               overflow_reg;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = ((wr_ptr_reg - rd_ptr_reg) == DEPTH_PTR);
  assign pop        = ~fifo_empty & evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push       = emit & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= {emit_repeat, emit_break, emit_ext, in_data};
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (emit & ~push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign head       = mem[rd_ptr_reg[ADDR_W-1:0]];
  assign evt_valid  = ~fifo_empty;
  assign evt_code   = evt_valid ? head[7:0] : 8'h00;
  assign evt_ext    = evt_valid & head[8];
  assign evt_break  = evt_valid & head[9];
  assign evt_repeat = evt_valid & head[10];
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: feeds scan-code bytes through the
// ready/nextdata_n handshake and checks events, counters and held/modifier state.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_ready = 1'b0;
  logic       in_nextdata_n;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_repeat, overflow;
  logic [7:0] press_count;
  logic       held_valid, held_ext;
  logic [7:0] held_code;
  logic       shift, ctrl;

  int errors = 0;
  int checks = 0;

  ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_DIGITS(2)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .in_nextdata_n (in_nextdata_n),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_code      (evt_code),
    .evt_ext       (evt_ext),
    .evt_break     (evt_break),
    .evt_repeat    (evt_repeat),
    .overflow      (overflow),
    .press_count   (press_count),
    .held_valid    (held_valid),
    .held_ext      (held_ext),
    .held_code     (held_code),
    .shift         (shift),
    .ctrl          (ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a byte, expect exactly one 1-cycle low acknowledge
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_ready = 1'b1;
    @(posedge clk); #1;
    chk("ack_low", in_nextdata_n, 1'b0);
    in_ready = 1'b0;
    @(posedge clk); #1;
    chk("ack_high", in_nextdata_n, 1'b1);
    $display("byte %h sent, press_count=%h", b, press_count);
  endtask

  task automatic expect_evt(input string tag, input logic [7:0] code,
                            input logic ext, input logic brk, input logic rep);
    chk({tag, "_valid"}, evt_valid, 1'b1);
    chk({tag, "_code"}, evt_code, code);
    chk({tag, "_ext"}, evt_ext, ext);
    chk({tag, "_break"}, evt_break, brk);
    chk({tag, "_repeat"}, evt_repeat, rep);
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    $display("event %s popped: code=%h ext=%b break=%b repeat=%b", tag, code, ext, brk, rep);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ack"}, in_nextdata_n, 1'b1);
    chk({tag, "_valid"}, evt_valid, 1'b0);
    chk({tag, "_code"}, evt_code, 8'h00);
    chk({tag, "_flags"}, {evt_ext, evt_break, evt_repeat}, 3'b000);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_count"}, press_count, 8'h00);
    chk({tag, "_held"}, {held_valid, held_ext, held_code}, 10'h000);
    chk({tag, "_mods"}, {shift, ctrl}, 2'b00);
    $display("reset state checked (%s)", tag);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst0");
    clrn = 1'b0;

    // Press and release 'A'
    send_byte(8'h1C);
    chk("a_make_valid", evt_valid, 1'b1);
    chk("a_held", {held_valid, held_ext, held_code}, {1'b1, 1'b0, 8'h1C});
    chk("a_count", press_count, 8'h01);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("a_released", held_valid, 1'b0);
    expect_evt("a_make", 8'h1C, 1'b0, 1'b0, 1'b0);
    expect_evt("a_break", 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("a_empty", evt_valid, 1'b0);
    chk("a_count2", press_count, 8'h01);

    // Right ctrl (extended)
    send_byte(8'hE0);
    send_byte(8'h14);
    chk("rctrl_on", ctrl, 1'b1);
    chk("rctrl_held", {held_valid, held_ext, held_code}, {1'b1, 1'b1, 8'h14});
    chk("rctrl_count", press_count, 8'h02);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h14);
    chk("rctrl_off", ctrl, 1'b0);
    expect_evt("rctrl_make", 8'h14, 1'b1, 1'b0, 1'b0);
    expect_evt("rctrl_break", 8'h14, 1'b1, 1'b1, 1'b0);

    // Typematic repeats
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    chk("typ_count", press_count, 8'h03);
    send_byte(8'hF0);
    send_byte(8'h1C);
    expect_evt("typ0", 8'h1C, 1'b0, 1'b0, 1'b0);
    expect_evt("typ1", 8'h1C, 1'b0, 1'b0, 1'b1);
    expect_evt("typ2", 8'h1C, 1'b0, 1'b0, 1'b1);
    expect_evt("typ_brk", 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("typ_count2", press_count, 8'h03);

    // Shift overlap
    send_byte(8'h12);
    chk("lshift_on", shift, 1'b1);
    send_byte(8'h59);
    send_byte(8'hF0);
    send_byte(8'h12);
    chk("shift_overlap", shift, 1'b1);
    chk("shift_held", {held_valid, held_code}, {1'b1, 8'h59});
    send_byte(8'hF0);
    send_byte(8'h59);
    chk("shift_off", shift, 1'b0);
    chk("shift_unheld", held_valid, 1'b0);
    chk("shift_count", press_count, 8'h05);
    expect_evt("ls_make", 8'h12, 1'b0, 1'b0, 1'b0);
    expect_evt("rs_make", 8'h59, 1'b0, 1'b0, 1'b0);
    expect_evt("ls_break", 8'h12, 1'b0, 1'b1, 1'b0);
    expect_evt("rs_break", 8'h59, 1'b0, 1'b1, 1'b0);

    // Prefix restart (E0 after F0) and discarded byte after E0
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'hFF);
    send_byte(8'h1C);
    chk("restart_count", press_count, 8'h07);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("restart_unheld", held_valid, 1'b0);
    expect_evt("restart_ext", 8'h1C, 1'b1, 1'b0, 1'b0);
    expect_evt("discard_make", 8'h1C, 1'b0, 1'b0, 1'b0);
    expect_evt("discard_break", 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("restart_empty", evt_valid, 1'b0);

    // FIFO overflow with consumer stalled
    for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i));
    chk("full_no_ovf", overflow, 1'b0);
    send_byte(8'h29);
    chk("full_ovf", overflow, 1'b1);
    chk("full_count", press_count, 8'h16);
    chk("full_held", held_code, 8'h29);
    for (int i = 0; i < 8; i++) expect_evt("fifo", 8'h21 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("drained", evt_valid, 1'b0);

    // BCD wrap: alternate two keys so every make is a new press
    for (int i = 0; i < 83; i++) send_byte((i % 2 == 1) ? 8'h32 : 8'h1C);
    chk("count_99", press_count, 8'h99);
    send_byte(8'h32);
    chk("count_wrap", press_count, 8'h00);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset mid-sequence after E0
    send_byte(8'hE0);
    clrn = 1'b1;
    @(posedge clk); #1;
    clrn = 1'b0;
    check_reset_state("rst1");
    send_byte(8'h1C);
    chk("post_rst_count", press_count, 8'h01);
    expect_evt("post_rst", 8'h1C, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised key-event decoder sitting between `ps2_keyboard` and display or consumer logic. It drains scan-code bytes via the `ready`/`nextdata_n` handshake and assembles E0/F0 prefix sequences into single make/break events. Held-key typematic repeats are flagged, shift/ctrl modifier state is tracked, and distinct key presses are counted in a BCD counter. Events are buffered in a first-word-fall-through FIFO with a ready/valid output.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of two and at least 2.
- `CNT_DIGITS`, default 2: number of BCD digits in the press counter.
- `clk` in 1: system clock; all state changes on the rising edge.
- `clrn` in 1: reset. One clock; reset is asynchronous and active-high (asserted = 1 despite the port name).
- `in_data` in 8: byte from `ps2_keyboard` `data`.
- `in_ready` in 1: `ps2_keyboard` `ready`.
- `in_nextdata_n` out 1: drives `ps2_keyboard` `nextdata_n`; active-low one-cycle acknowledge.
- `evt_valid` out 1: FIFO non-empty.
- `evt_ready` in 1: consumer pops the head when `evt_valid & evt_ready`.
- `evt_code` out 8: head event scan code, without prefixes.
- `evt_ext` out 1: head event carried an E0 prefix.
- `evt_break` out 1: head event is a release (F0 prefix).
- `evt_repeat` out 1: head event is a typematic repeat make.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `press_count` out 4*CNT_DIGITS: BCD count of non-repeat make events; digit 0 is the LSBs.
- `held_valid` out 1, `held_ext` out 1, `held_code` out 8: last key made and not yet released.
- `shift` out 1, `ctrl` out 1: modifier currently held.

## Operation
- Byte acceptance:
  - On an edge where `in_ready=1` and `in_nextdata_n=1`, the block captures `in_data` and registers `in_nextdata_n<=0`.
  - On the next edge it unconditionally returns `in_nextdata_n<=1`.
  - Exactly one byte is captured per low pulse. `in_ready` is ignored while `in_nextdata_n=0`.
- Prefix FSM states: IDLE, E0, F0, E0F0. Transitions on each captured byte:
  - 0xE0: IDLE→E0.
  - 0xF0: IDLE→F0, E0→E0F0.
  - 0x00, 0xFF, 0xE1: discarded; FSM→IDLE.
  - Any other byte: emit event {code=byte, ext=(state∈{E0,E0F0}), break=(state∈{F0,E0F0})}; FSM→IDLE.
  - A prefix in an unexpected state (e.g. 0xE0 in F0, 0xF0 in E0F0) restarts decoding as if received in IDLE.
- Emitted make event:
  - If it matches `held` ({ext,code} equal and `held_valid=1`): `repeat=1`, counter unchanged.
  - Otherwise: `repeat=0`, `held<=`{ext,code}, `held_valid<=1`, press counter +1.
- Emitted break event:
  - If it matches `held`: `held_valid<=0`.
  - Otherwise: `held` is unchanged.
- Modifiers, updated on make/break, repeats included:
  - `shift`: left 0x12 and right 0x59, non-ext; tracked independently; `shift` = OR of the two.
  - `ctrl`: 0x14, ext or non-ext, tracked independently; `ctrl` = OR of the two.
- Press counter: BCD, CNT_DIGITS digits. Each digit wraps 9→0 with carry; all-9s wraps to all-0 with no flag.
- FIFO, first-word-fall-through:
  - Push on emit. If full and no pop this cycle: drop the event and set `overflow<=1`.
  - If full with a simultaneous pop: push accepted.
- Counter, held and modifier state update even when the event is dropped.
- `overflow` is cleared only by reset.

## Timing
- Reset values: `in_nextdata_n=1`, `evt_valid=0`, `evt_code=0`, `evt_ext=0`, `evt_break=0`, `evt_repeat=0`, `overflow=0`, `press_count=0`, `held_valid=0`, `held_ext=0`, `held_code=0`, `shift=0`, `ctrl=0`, FSM=IDLE, FIFO empty.
- Reset asserted mid-sequence (e.g. after 0xE0): FSM returns to IDLE and the partial sequence is lost.
- Capture edge C of the final byte: at C the FIFO write, counter, held and modifier updates all occur. `evt_valid` rises after C if the FIFO was empty. There is no bypass: an empty FIFO with a same-cycle push shows valid one cycle later.
- Byte throughput: at most one byte per two cycles, since the acknowledge pulse is 1 cycle and re-arm takes 1 cycle.
- Pop: head advances at an edge where `evt_valid & evt_ready`. The next entry is visible the following cycle.

## Test plan
- Press/release 'A': bytes 1C, F0, 1C → two events {1C,make}, {1C,break}; `press_count`=01; `held_valid` goes 1 then 0; each byte gets exactly one 1-cycle `in_nextdata_n` low pulse.
- Extended right ctrl: E0 14, E0 F0 14 → {14,ext,make}, {14,ext,break}; `ctrl` goes 1 then 0.
- Typematic: 1C ×3, then F0 1C → `evt_repeat` sequence 0,1,1 then a break; `press_count`=01.
- Shift overlap: 12, 59, F0 12 → `shift` stays 1; after F0 59 → `shift`=0.
- FIFO full: with `evt_ready=0`, send FIFO_DEPTH+1 makes of distinct keys → `overflow`=1; first FIFO_DEPTH events are intact; `press_count`=FIFO_DEPTH+1 in BCD (09 for the default).
- Counter wrap (CNT_DIGITS=2): 100 distinct non-repeat makes → 99 then 00. Reset asserted after an E0 → the next 1C is a non-ext make.
